// File: rtl/lc_pkg.sv
// Shared types and geometry for the lower-cache line responder.
package lc_pkg;

  localparam int PADDR_BITS = 22;
  localparam int B          = 64;
  localparam int LINE_BITS  = 8 * B;
  localparam int OFF_BITS   = $clog2(B);

  // One queued request; addr is already line-aligned when stored.
  typedef struct packed {
    logic [PADDR_BITS-1:0] addr;
    logic [LINE_BITS-1:0]  data;
    logic                  we;
  } lc_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lc_state_e;

  // Clear the byte-offset bits so every stored/returned address names a whole line.
  function automatic logic [PADDR_BITS-1:0] line_align(input logic [PADDR_BITS-1:0] a);
    return a & ~PADDR_BITS'(B - 1);
  endfunction

endpackage

// File: rtl/lc_req_fifo.sv
// Request FIFO: QDEPTH entries, pointers carry an extra wrap bit to tell full from empty.
module lc_req_fifo
  import lc_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  lc_req_t data_i,
  input  logic    pop_i,
  output lc_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(QDEPTH);

  lc_req_t        mem_q [QDEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; push and pop are ignored when they would over/underflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i && !full_o) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/lc_line_responder.sv
// L2 stand-in for the L1D line interface: queued line reads/writes against a
// small backing store with a fixed access latency.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  IDLE    | nothing in flight; start the FIFO head if one is queued
//  WAIT    | latency timer running for the FIFO head
//  RESP    | read fill presented, held until the L1 takes it
module lc_line_responder
  import lc_pkg::*;
#(
  parameter int DEPTH_LINES = 64,
  parameter int LATENCY     = 4,
  parameter int QDEPTH      = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic [PADDR_BITS-1:0] req_addr_in,
  input  logic [LINE_BITS-1:0]  req_value_in,
  input  logic                  req_we_in,
  output logic                  resp_valid_out,
  input  logic                  resp_ready_in,
  output logic [PADDR_BITS-1:0] resp_addr_out,
  output logic [LINE_BITS-1:0]  resp_value_out,
  output logic [15:0]           rd_count_out,
  output logic [15:0]           wr_count_out
);

  localparam int IDX_BITS = $clog2(DEPTH_LINES);
  localparam int CW       = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  // IDLE already spends one cycle of the latency, WAIT counts the rest down to 0.
  localparam logic [CW-1:0] CNT_LOAD = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  lc_state_e               state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    finish;
  logic                    pop;
  logic                    commit_wr;
  logic                    capture_rd;

  logic                    push;
  lc_req_t                 push_req;
  lc_req_t                 head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [IDX_BITS-1:0]     head_idx;

  logic [LINE_BITS-1:0]    line_q [DEPTH_LINES];
  logic [DEPTH_LINES-1:0]  line_vld_q;

  logic [PADDR_BITS-1:0]   resp_addr_q;
  logic [LINE_BITS-1:0]    resp_value_q;
  logic [15:0]             rd_cnt_q, wr_cnt_q;

  assign req_ready_out  = !fifo_full;
  assign push           = req_valid_in && !fifo_full;
  assign push_req.addr  = line_align(req_addr_in);
  assign push_req.data  = req_value_in;
  assign push_req.we    = req_we_in;
  assign head_idx       = head.addr[OFF_BITS +: IDX_BITS];

  assign resp_valid_out = (state_q == ST_RESP);
  assign resp_addr_out  = resp_addr_q;
  assign resp_value_out = resp_value_q;
  assign rd_count_out   = rd_cnt_q;
  assign wr_count_out   = wr_cnt_q;

  lc_req_fifo #(
    .QDEPTH (QDEPTH)
  ) u_req_fifo (
    .clk_i   (clk_in),
    .rst_ni  (rst_N_in),
    .push_i  (push),
    .data_i  (push_req),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sequencer next-state: start head, time the access, complete write or read.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    finish     = 1'b0;
    pop        = 1'b0;
    commit_wr  = 1'b0;
    capture_rd = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (LATENCY <= 1) begin
            finish = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) finish = 1'b1;
        else             cnt_d  = cnt_q - CW'(1);
      end
      ST_RESP: begin
        if (resp_ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (finish) begin
      pop = 1'b1;
      if (head.we) begin
        commit_wr = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        capture_rd = 1'b1;
        state_d    = ST_RESP;
      end
    end
  end

  // Sequencer state and latency timer.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Line data array; only the valid bits are reset, so stale data is never returned.
  always_ff @(posedge clk_in) begin
    if (commit_wr) line_q[head_idx] <= head.data;
  end

  // Line valid bits.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in)      line_vld_q           <= '0;
    else if (commit_wr) line_vld_q[head_idx] <= 1'b1;
  end

  // Response register, loaded when a read completes and held through RESP.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      resp_addr_q  <= '0;
      resp_value_q <= '0;
    end else if (capture_rd) begin
      resp_addr_q  <= head.addr;
      resp_value_q <= line_vld_q[head_idx] ? line_q[head_idx] : '0;
    end
  end

  // Saturating accept counters.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (push) begin
      if (!req_we_in && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (req_we_in && wr_cnt_q != 16'hFFFF)  wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_lc_line_responder.sv
// Randomized and directed bench for lc_line_responder against an in-order line-store model.
module tb_lc_line_responder;

  localparam int PB = 22;
  localparam int LB = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [PB-1:0] req_addr = '0;
  logic [LB-1:0] req_value = '0;
  logic          req_we = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [PB-1:0] resp_addr;
  logic [LB-1:0] resp_value;
  logic [15:0]   rd_count;
  logic [15:0]   wr_count;

  lc_line_responder dut (
    .clk_in         (clk),
    .rst_N_in       (rst_n),
    .req_valid_in   (req_valid),
    .req_ready_out  (req_ready),
    .req_addr_in    (req_addr),
    .req_value_in   (req_value),
    .req_we_in      (req_we),
    .resp_valid_out (resp_valid),
    .resp_ready_in  (resp_ready),
    .resp_addr_out  (resp_addr),
    .resp_value_out (resp_value),
    .rd_count_out   (rd_count),
    .wr_count_out   (wr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 64-line store keyed by line index, expected fills in order.
  logic [LB-1:0] mdl_mem [int];
  logic [PB-1:0] exp_addr_q [$];
  logic [LB-1:0] exp_val_q [$];
  int            mdl_rd = 0;
  int            mdl_wr = 0;
  int            n_resp = 0;
  logic          held = 1'b0;
  logic [PB-1:0] held_addr;
  logic [LB-1:0] held_val;

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [PB-1:0] a);
    return (int'(a) / 64) % 64;
  endfunction

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [15:0] sat16(input int n);
    return (n > 65535) ? 16'hFFFF : n[15:0];
  endfunction

  // One clock: drive inputs, observe at the falling edge, update the model for this edge.
  task automatic cycle(input logic v, input logic [PB-1:0] a, input logic we,
                       input logic [LB-1:0] d, input logic rr, output logic acc);
    int k;
    req_valid = v; req_addr = a; req_we = we; req_value = d; resp_ready = rr;
    @(negedge clk);
    acc = v && req_ready;
    if (held && resp_valid) begin
      chk("hold_addr", resp_addr, held_addr);
      chk("hold_value", resp_value, held_val);
    end
    if (resp_valid && rr) begin
      n_resp++;
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        chk("resp_addr", resp_addr, exp_addr_q.pop_front());
        chk("resp_value", resp_value, exp_val_q.pop_front());
      end
      held = 1'b0;
    end else if (resp_valid) begin
      held = 1'b1; held_addr = resp_addr; held_val = resp_value;
    end else begin
      held = 1'b0;
    end
    if (acc) begin
      k = line_of(a);
      if (we) begin
        mdl_mem[k] = d;
        mdl_wr++;
      end else begin
        exp_addr_q.push_back(a & ~PB'(63));
        exp_val_q.push_back(mdl_mem.exists(k) ? mdl_mem[k] : '0);
        mdl_rd++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, rr, acc);
  endtask

  // Hold a request until accepted, with a bound.
  task automatic send(input logic [PB-1:0] a, input logic we, input logic [LB-1:0] d, input logic rr);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 60) begin
      cycle(1'b1, a, we, d, rr, acc);
      tries++;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_addr_q.size() != 0 && t < 300) begin
      idle(1, 1'b1);
      t++;
    end
    chk("drain_empty", exp_addr_q.size(), 0);
    idle(8, 1'b1);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_rd_cnt"}, rd_count, sat16(mdl_rd));
    chk({tag, "_wr_cnt"}, wr_count, sat16(mdl_wr));
  endtask

  task automatic apply_reset();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rd_cnt", rd_count, 0);
    chk("rst_wr_cnt", wr_count, 0);
    mdl_mem.delete();
    exp_addr_q.delete();
    exp_val_q.delete();
    mdl_rd = 0; mdl_wr = 0; held = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
  endtask

  initial begin
    int lat;
    int r0;
    int acc_cnt;
    logic acc;
    logic [PB-1:0] a;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_addr", resp_addr, 0);
    chk("reset_resp_value", resp_value, 0);
    chk("reset_rd_cnt", rd_count, 0);
    chk("reset_wr_cnt", wr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_ready", req_ready, 1);

    // Cold read: fill visible LATENCY edges after the accepting edge, all-zero line.
    send(22'h060300, 1'b0, '0, 1'b1);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("cold_latency", lat, 4);
    idle(1, 1'b1);
    chk("cold_rd_cnt", rd_count, 1);
    drain();

    // Write then read within the same line: single response, written data.
    r0 = n_resp;
    send(22'h004040, 1'b1, LB'(32'hC0C0C0C0), 1'b1);
    send(22'h004050, 1'b0, '0, 1'b1);
    drain();
    chk("raw_one_resp", n_resp - r0, 1);
    chk_counts("raw");

    // Backpressure: first fill held, FIFO fills, sixth read blocked, then in-order drain.
    for (int i = 0; i < 5; i++) send(PB'(22'h010000 + i * 64), 1'b0, '0, 1'b0);
    acc_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 22'h010140, 1'b0, '0, 1'b0, acc);
      if (acc) acc_cnt++;
    end
    chk("full_blocked", acc_cnt, 0);
    chk("full_ready_low", req_ready, 0);
    chk("full_resp_held", resp_valid, 1);
    if (acc_cnt == 0) send(22'h010140, 1'b0, '0, 1'b1);
    drain();
    chk_counts("bp");

    // Aliasing: addresses differing above the index bits share a line.
    send(22'h000000, 1'b1, LB'(32'hDEADBEEF), 1'b1);
    send(22'h001000, 1'b0, '0, 1'b1);
    drain();

    // Randomized traffic over a handful of lines, random backpressure.
    for (int i = 0; i < 400; i++) begin
      a = PB'($urandom);
      a[11:6] = 6'($urandom_range(0, 7));
      cycle(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), rand_line(),
            ($urandom_range(0, 3) != 0), acc);
    end
    drain();
    chk_counts("rand");

    // Reset during WAIT: request discarded, no fill afterwards, counters cleared.
    send(22'h002000, 1'b0, '0, 1'b1);
    idle(1, 1'b1);
    r0 = n_resp;
    apply_reset();
    idle(12, 1'b1);
    chk("post_rst_no_resp", n_resp - r0, 0);
    chk_counts("post_rst");

    // Valid bits cleared by reset: previously written line reads back as zero.
    send(22'h004040, 1'b0, '0, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
